alu_issue_stage: RTL and testbench

//  Issue side of the 32-bit ALU interface (Aluctl/A/B/shift_amount).
//  - Decodes ALUOp+funct into the ALU's 4-bit control code.
//  - Selects the operands.
//  - Registers everything into a 2-entry valid/ready skid stage (ID->EX boundary).
//  - Upstream decode and the downstream EX stage can stall independently without losing ops.

---
 rtl/alu_issue_if.sv | 38 +++
 rtl/alu_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between ID decode, the ALU issue
// stage and the EX stage.
//   Upstream   : in_valid/in_ready, alu_op, funct, shamt, alu_src, rs_data, rt_data, imm
//   Downstream : out_valid/out_ready, aluctl, alu_a, alu_b, shift_amount
// Modports:
//   slave  - the issue stage (consumes upstream, produces downstream)
//   master - the environment around it (decode + EX)
interface alu_issue_if #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic              alu_src;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [IMM_W-1:0]  imm;

  logic              out_valid;
  logic              out_ready;
  logic [3:0]        aluctl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        shift_amount;

  modport slave (
    input  in_valid, alu_op, funct, shamt, alu_src, rs_data, rt_data, imm, out_ready,
    output in_ready, out_valid, aluctl, alu_a, alu_b, shift_amount
  );

  modport master (
    output in_valid, alu_op, funct, shamt, alu_src, rs_data, rt_data, imm, out_ready,
    input  in_ready, out_valid, aluctl, alu_a, alu_b, shift_amount
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue side of the 32-bit ALU. Decodes ALUOp+funct into the
// 4-bit ALU control code, selects operands, and holds ops in a 2-entry
// valid/ready skid stage at the ID->EX boundary (1-cycle latency, 1 op/cycle).
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, drops every held op and any concurrent input
//   bus          alu_issue_if.slave (upstream op + downstream ALU request)
//   illegal_err  sticky illegal-funct flag
// Optional feature: define ALU_ISSUE_ILLEGAL_TRAP_EN to swallow illegal ops
// (accepted but never issued) and raise illegal_err until reset. Without it,
// illegal ops are issued with aluctl=4'hF and illegal_err is tied low.
module alu_issue_stage #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32  // fixed to the ALU width
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_issue_if.slave   bus,
  output logic         illegal_err
);

  localparam logic [3:0] CtlIllegal = 4'hF;

  typedef struct packed {
    logic [3:0]        ctl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        sh;
  } op_t;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e state_q;
  op_t    out_q;
  op_t    skid_q;
  logic   out_valid_q;
  logic   in_ready_q;
  op_t    dec_op;
  logic   is_sll;
  logic   accept;
  logic   drain;
  logic   load;

  // Decode and operand select
  always_comb begin
    dec_op     = '0;
    dec_op.ctl = CtlIllegal;
    unique case (bus.alu_op)
      2'b00: dec_op.ctl = 4'd2;
      2'b01: dec_op.ctl = 4'd6;
      2'b11: dec_op.ctl = 4'd1;
      2'b10: begin
        case (bus.funct)
          6'h20:   dec_op.ctl = 4'd2;
          6'h22:   dec_op.ctl = 4'd6;
          6'h24:   dec_op.ctl = 4'd0;
          6'h25:   dec_op.ctl = 4'd1;
          6'h2A:   dec_op.ctl = 4'd7;
          6'h27:   dec_op.ctl = 4'd12;
          6'h00:   dec_op.ctl = 4'd10;
          default: dec_op.ctl = CtlIllegal;
        endcase
      end
      default: dec_op.ctl = CtlIllegal;
    endcase

    is_sll = (bus.alu_op == 2'b10) && (bus.funct == 6'h00);
    if (is_sll) begin
      // Shifts operate on rt; rs is ignored
      dec_op.a  = bus.rt_data;
      dec_op.b  = '0;
      dec_op.sh = bus.shamt;
    end else begin
      dec_op.a  = bus.rs_data;
      dec_op.b  = bus.alu_src ? {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.rt_data;
      dec_op.sh = '0;
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q;
  assign dec_illegal = (dec_op.ctl == CtlIllegal);
  // Illegal ops complete the handshake but become a bubble
  assign load        = accept & ~dec_illegal;
  assign illegal_err = illegal_q;
`else
  assign load        = accept;
  assign illegal_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Flush wins over accept and drain; a concurrent input op is lost
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      if (accept && dec_illegal) begin
        illegal_q <= 1'b1;
      end
`endif
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            out_q       <= dec_op;
            out_valid_q <= 1'b1;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (load && drain) begin
            out_q <= dec_op;
          end else if (load) begin
            skid_q     <= dec_op;
            in_ready_q <= 1'b0;
            state_q    <= StFull;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so nothing new can arrive
          if (drain) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= StBusy;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.aluctl       = out_q.ctl;
  assign bus.alu_a        = out_q.a;
  assign bus.alu_b        = out_q.b;
  assign bus.shift_amount = out_q.sh;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed, table-driven bench for alu_issue_stage.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic illegal_err;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_if #(.IMM_W(16), .DATA_W(32)) bus ();

  alu_issue_stage #(.IMM_W(16), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .illegal_err (illegal_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic        alu_src;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_sh;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sa,
                          input logic src, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.shamt    = sa;
    bus.alu_src  = src;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm      = imm;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".aluctl"}, {28'd0, bus.aluctl}, {28'd0, ctl});
    chk({tag, ".alu_a"}, bus.alu_a, a);
    chk({tag, ".alu_b"}, bus.alu_b, b);
    chk({tag, ".shift_amount"}, {27'd0, bus.shift_amount}, {27'd0, sh});
  endtask

  initial begin
    //         op     funct  sh    src   rs            rt            imm       ctl    A             B             sh
    vecs[0]  = '{2'b10, 6'h20, 5'd0, 1'b0, 32'd5,        32'd7,        16'h0000, 4'd2,  32'd5,        32'd7,        5'd0};
    vecs[1]  = '{2'b10, 6'h00, 5'd4, 1'b0, 32'h99,       32'h1,        16'h0000, 4'd10, 32'h1,        32'h0,        5'd4};
    vecs[2]  = '{2'b00, 6'h3F, 5'd0, 1'b1, 32'h100,      32'h5,        16'hFFFC, 4'd2,  32'h100,      32'hFFFFFFFC, 5'd0};
    vecs[3]  = '{2'b00, 6'h00, 5'd0, 1'b1, 32'h200,      32'h5,        16'h7FFF, 4'd2,  32'h200,      32'h00007FFF, 5'd0};
    vecs[4]  = '{2'b01, 6'h00, 5'd0, 1'b0, 32'd9,        32'd3,        16'h1234, 4'd6,  32'd9,        32'd3,        5'd0};
    vecs[5]  = '{2'b11, 6'h00, 5'd0, 1'b1, 32'h0F,       32'h77,       16'h00F0, 4'd1,  32'h0F,       32'h000000F0, 5'd0};
    vecs[6]  = '{2'b10, 6'h22, 5'd3, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 16'h0000, 4'd6,  32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0};
    vecs[7]  = '{2'b10, 6'h24, 5'd3, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 4'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0};
    vecs[8]  = '{2'b10, 6'h25, 5'd3, 1'b0, 32'h1,        32'h2,        16'h0000, 4'd1,  32'h1,        32'h2,        5'd0};
    vecs[9]  = '{2'b10, 6'h2A, 5'd3, 1'b0, 32'hFFFFFFFF, 32'h1,        16'h0000, 4'd7,  32'hFFFFFFFF, 32'h1,        5'd0};
    vecs[10] = '{2'b10, 6'h27, 5'd3, 1'b0, 32'h3,        32'h4,        16'h0000, 4'd12, 32'h3,        32'h4,        5'd0};
    vecs[11] = '{2'b10, 6'h00, 5'd31, 1'b1, 32'h5,       32'h80000001, 16'hFFFF, 4'd10, 32'h80000001, 32'h0,        5'd31};
    vecs[12] = '{2'b10, 6'h20, 5'd0, 1'b1, 32'h10,       32'h20,       16'h8000, 4'd2,  32'h10,       32'hFFFF8000, 5'd0};

    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = 6'h00;
    bus.shamt     = 5'd0;
    bus.alu_src   = 1'b0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.imm       = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.aluctl", {28'd0, bus.aluctl}, 32'd0);
    chk("rst.alu_a", bus.alu_a, 32'd0);
    chk("rst.alu_b", bus.alu_b, 32'd0);
    chk("rst.shift_amount", {27'd0, bus.shift_amount}, 32'd0);
    chk("rst.illegal_err", {31'd0, illegal_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back decode vectors, 1 op/cycle with out_ready held high
    for (int i = 0; i < 13; i++) begin
      drive_op(vecs[i].alu_op, vecs[i].funct, vecs[i].shamt, vecs[i].alu_src,
               vecs[i].rs, vecs[i].rt, vecs[i].imm);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_sh);
      chk($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Back-pressure: X out, Y in skid, Z held upstream, then in-order drain
    bus.out_ready = 1'b0;
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h11, 32'h0, 16'h0);
    step();
    chk("bp.x_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.x_a", bus.alu_a, 32'h11);
    chk("bp.ready1", {31'd0, bus.in_ready}, 32'd1);
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h22, 32'h0, 16'h0);
    step();
    chk("bp.full_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp.full_a", bus.alu_a, 32'h11);
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h33, 32'h0, 16'h0);
    step();
    step();
    chk("bp.hold_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp.hold_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.hold_a", bus.alu_a, 32'h11);
    bus.out_ready = 1'b1;
    step();
    chk("bp.y_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.y_a", bus.alu_a, 32'h22);
    chk("bp.y_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp.z_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.z_a", bus.alu_a, 32'h33);
    step();
    chk("bp.empty_valid", {31'd0, bus.out_valid}, 32'd0);

    // Flush while FULL with a third op offered
    bus.out_ready = 1'b0;
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h44, 32'h0, 16'h0);
    step();
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h55, 32'h0, 16'h0);
    step();
    chk("fl.full_ready", {31'd0, bus.in_ready}, 32'd0);
    drive_op(2'b10, 6'h20, 5'd0, 1'b0, 32'h66, 32'h0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("fl.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl.in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl.quiet%0d", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Illegal funct
    drive_op(2'b10, 6'h3F, 5'd0, 1'b0, 32'h1, 32'h2, 16'h0);
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    chk("ill.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ill.err", {31'd0, illegal_err}, 32'd1);
    step();
    step();
    chk("ill.sticky", {31'd0, illegal_err}, 32'd1);
`else
    check_out("ill", 4'hF, 32'h1, 32'h2, 5'd0);
    chk("ill.err", {31'd0, illegal_err}, 32'd0);
    step();
    chk("ill.drained", {31'd0, bus.out_valid}, 32'd0);
`endif

    // Reset mid-operation discards held ops and clears the sticky flag
    bus.out_ready = 1'b0;
    drive_op(2'b11, 6'h00, 5'd0, 1'b1, 32'h7, 32'h0, 16'h0008);
    step();
    drive_op(2'b11, 6'h00, 5'd0, 1'b1, 32'h8, 32'h0, 16'h0008);
    step();
    chk("mr.pre_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mr.pre_ctl", {28'd0, bus.aluctl}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mr.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mr.aluctl", {28'd0, bus.aluctl}, 32'd0);
    chk("mr.alu_a", bus.alu_a, 32'd0);
    chk("mr.illegal_err", {31'd0, illegal_err}, 32'd0);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("mr.after_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
